// File: rtl/input_debouncer_pkg.sv
// Shared constants and helpers for the input debouncer.
`timescale 1ns/1ps
package input_debouncer_pkg;

  localparam int DEBOUNCE_TICKS_DEFAULT = 10000;

  // Counter width for a given qualification length; never narrower than one bit.
  function automatic int cnt_width(input int ticks);
    int w;
    w = $clog2(ticks);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a single asynchronous bit, async active-low reset.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Debounces a single-bit input: o follows i only after TICKS stable cycles.
// Define DEBOUNCER_SYNC_EN to insert a 2-flop synchronizer in front of the filter.
`timescale 1ns/1ps
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int TICKS = DEBOUNCE_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i,
  output logic o
);

  localparam int            CW   = cnt_width(TICKS);
  localparam logic [CW-1:0] TERM = CW'(TICKS - 1);

  logic          s;
  logic [CW-1:0] cnt;

`ifdef DEBOUNCER_SYNC_EN
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i),
    .q   (s)
  );
`else
  assign s = i;
`endif

  // Any return of s to o restarts qualification; commit clears the counter,
  // so it can never run past TERM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o   <= 1'b0;
      cnt <= '0;
    end else if (s == o) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      o   <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: a TICKS=16 instance and a TICKS=10000 instance.
`timescale 1ns/1ps
module tb_input_debouncer;

  localparam int T_A = 16;
  localparam int T_B = 10000;
`ifdef DEBOUNCER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  // Edge (counting the first edge after the change as 1) on which o moves.
  localparam int LAT_A = T_A + SYNC_LAT;
  localparam int LAT_B = T_B + SYNC_LAT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_a = 1'b0;
  logic i_b = 1'b0;
  logic o_a;
  logic o_b;

  int total  = 0;
  int bad    = 0;
  int rise_b = 0;

  // clock / reset block: 2-unit period, rising edges on odd integer times
  always #1 clk = ~clk;

  input_debouncer #(.TICKS(T_A)) dut_a (.clk(clk), .rst(rst), .i(i_a), .o(o_a));
  input_debouncer #(.TICKS(T_B)) dut_b (.clk(clk), .rst(rst), .i(i_b), .o(o_b));

  always @(posedge o_b) rise_b++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Let n rising edges pass, then park on the following falling edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  real t_final;
  int  n_edges;

  initial begin
    // reset held with i toggling, including between edges
    #0.2 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      i_a = ~i_a;
      #0.3 i_b = ~i_b;
      check_eq("rst_hold", {31'd0, o_a}, 32'd0);
    end
    @(negedge clk);
    i_a = 1'b0;
    i_b = 1'b0;
    check_eq("rst_hold_b", {31'd0, o_b}, 32'd0);
    rst = 1'b1;
    edges(LAT_A + 4);
    check_eq("post_rst", {31'd0, o_a}, 32'd0);

    // clean step
    i_a = 1'b1;
    edges(LAT_A - 1);
    check_eq("step_early", {31'd0, o_a}, 32'd0);
    edges(1);
    check_eq("step_edge", {31'd0, o_a}, 32'd1);
    edges(20);
    check_eq("step_hold", {31'd0, o_a}, 32'd1);

    // 15-cycle low pulse must be discarded
    i_a = 1'b0;
    edges(T_A - 1);
    i_a = 1'b1;
    for (int e = 0; e < 25; e++) begin
      edges(1);
      check_eq("thr15_hold", {31'd0, o_a}, 32'd1);
    end

    // 16-cycle low pulse must commit
    i_a = 1'b0;
    for (int e = 1; e <= LAT_A; e++) begin
      edges(1);
      if (e == LAT_A - 1) check_eq("thr16_early", {31'd0, o_a}, 32'd1);
      if (e == LAT_A) check_eq("thr16_edge", {31'd0, o_a}, 32'd0);
      if (e == T_A) i_a = 1'b1;
    end
    edges(LAT_A + 4);
    check_eq("thr_return", {31'd0, o_a}, 32'd1);

    // asynchronous reset clears o between clock edges
    #0.3 rst = 1'b0;
    #0.1 check_eq("async_rst", {31'd0, o_a}, 32'd0);
    @(negedge clk);
    i_a = 1'b0;
    rst = 1'b1;
    edges(4);

    // reset at count 10 discards the pending transition
    i_a = 1'b1;
    edges(SYNC_LAT + 10);
    rst = 1'b0;
    edges(2);
    check_eq("mid_rst", {31'd0, o_a}, 32'd0);
    rst = 1'b1;
    edges(LAT_A - 1);
    check_eq("mid_rst_early", {31'd0, o_a}, 32'd0);
    edges(1);
    check_eq("mid_rst_edge", {31'd0, o_a}, 32'd1);

    // bounce rejection on the TICKS=10000 instance, transitions off the edges
    rise_b = 0;
    @(negedge clk);
    #0.5 i_b = 1'b0;
    #2   i_b = 1'b1;
    #1   i_b = 1'b0;
    #1003 i_b = 1'b1;
    #2213 i_b = 1'b0;
    #2031 i_b = 1'b1;
    #1013 i_b = 1'b0;
    #3032;
    check_eq("bounce_quiet", {31'd0, o_b}, 32'd0);
    check_eq("bounce_no_rise", rise_b, 32'd0);
    i_b = 1'b1;
    t_final = $realtime;
    @(posedge clk);
    n_edges = 1;
    @(negedge clk);
    while (o_b !== 1'b1 && n_edges < 2 * LAT_B) begin
      @(posedge clk);
      n_edges++;
      @(negedge clk);
    end
    check_eq("bounce_lat", n_edges, LAT_B);
    #(t_final + 75607.0 - $realtime);
    check_eq("bounce_hold", {31'd0, o_b}, 32'd1);
    check_eq("bounce_once", rise_b, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
